sha256_queued_mm: RTL

Next-generation Avalon-MM front end for the existing `sha` core. It adds a parametrised block queue, so software can stage several 512-bit blocks of one or more messages back-to-back. An internal sequencer pulses the core's start, captures the final digest and raises an interrupt. It sits between the Avalon-MM interconnect and one `sha` core instance.

---
 rtl/sha256_mm_pkg.sv | 53 +++++
 rtl/sha.sv | 115 +++++++++++
 rtl/sha256_blk_fifo.sv | 54 +++++
 rtl/sha256_queued_mm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sha256_mm_pkg.sv
// Shared definitions for the queued SHA-256 Avalon-MM front end and its core:
// register addresses, CTRL/STATUS bit positions, sequencer state encoding and
// the SHA-256 round constants / initial hash value.
package sha256_mm_pkg;

  localparam logic [7:0] MSG_BASE    = 8'h00;
  localparam logic [7:0] CTRL        = 8'h10;
  localparam logic [7:0] STATUS      = 8'h11;
  localparam logic [7:0] DIGEST_BASE = 8'h80;

  localparam int CTRL_LAST   = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_DONE  = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_FIN
  } seq_state_t;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha.sv
// Iterative SHA-256 compression core, one round per clock.
// Ports: clk, reset_n (sync active-low), start (one-cycle pulse), message
// (512-bit block, sampled on start), last_block (sampled on start), done
// (level, set when the block is folded into the hash, cleared by start),
// digest (current chaining value H0..H7, MSW first).
// A block following a non-last block chains from the previous hash; a block
// following a last block (or reset) starts from the initial hash value.
module sha
  import sha256_mm_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] message,
  input  logic         last_block,
  output logic         done,
  output logic [255:0] digest
);
  logic [31:0] hv [8];
  logic [31:0] v  [8];
  logic [31:0] w  [16];
  logic [5:0]  rnd;
  logic        running;
  logic        fold;
  logic        chain;
  logic [31:0] t1;
  logic [31:0] t2;
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // w[0] is always the schedule word for the current round; w[15] receives
  // the word needed sixteen rounds from now.
  always_comb begin
    t1    = v[7] + big_s1(v[4]) + ch(v[4], v[5], v[6]) + K[rnd] + w[0];
    t2    = big_s0(v[0]) + maj(v[0], v[1], v[2]);
    w_new = sml_s1(w[14]) + w[9] + sml_s0(w[1]) + w[0];
  end

  always_comb begin
    digest = '0;
    for (int i = 0; i < 8; i++) digest[255 - 32*i -: 32] = hv[i];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      running <= 1'b0;
      fold    <= 1'b0;
      done    <= 1'b0;
      chain   <= 1'b0;
      rnd     <= '0;
      for (int i = 0; i < 8; i++) hv[i] <= '0;
    end else if (start) begin
      running <= 1'b1;
      fold    <= 1'b0;
      done    <= 1'b0;
      rnd     <= '0;
      chain   <= ~last_block;
      for (int i = 0; i < 8; i++) begin
        v[i] <= chain ? hv[i] : IV[i];
        if (!chain) hv[i] <= IV[i];
      end
      for (int i = 0; i < 16; i++) w[i] <= message[511 - 32*i -: 32];
    end else if (running) begin
      v[0] <= t1 + t2;
      v[1] <= v[0];
      v[2] <= v[1];
      v[3] <= v[2];
      v[4] <= v[3] + t1;
      v[5] <= v[4];
      v[6] <= v[5];
      v[7] <= v[6];
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      rnd   <= rnd + 6'd1;
      if (rnd == 6'd63) begin
        running <= 1'b0;
        fold    <= 1'b1;
      end
    end else if (fold) begin
      for (int i = 0; i < 8; i++) hv[i] <= hv[i] + v[i];
      fold <= 1'b0;
      done <= 1'b1;
    end
  end

endmodule

// File: rtl/sha256_blk_fifo.sv
// Synchronous block FIFO with show-ahead output.
// Ports: clk/rst (sync active-high), push/din write side, pop read side,
// dout (current head, valid while !empty), full, empty, count (occupancy).
// Push while full and pop while empty are ignored.
module sha256_blk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 513
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sha256_queued_mm.sv
// Avalon-MM front end for the sha core with a block queue.
// Ports: iClk, iReset (sync active-high), iChipSelect_n/iWrite_n/iRead_n
// (active-low bus strobes), iAddress (word address), iData (write data),
// oData (registered read data, updated the cycle after a read strobe),
// oIrq (level interrupt = irq_en & done_sticky, registered).
// Software fills the 16-word staging buffer and commits it (with a last flag)
// into the queue; the sequencer feeds queued blocks to the core one at a
// time and latches the digest when a last block completes.
module sha256_queued_mm
  import sha256_mm_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int ADDR_W = 8
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iChipSelect_n,
  input  logic              iWrite_n,
  input  logic              iRead_n,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [31:0]       iData,
  output logic [31:0]       oData,
  output logic              oIrq
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic [31:0]   stg [16];
  logic [511:0]  staging;
  logic [255:0]  digest_q;
  logic          irq_en;
  logic          done_sticky;
  logic          overflow;

  logic          wr;
  logic          rd;
  logic          is_msg;
  logic          is_ctrl;
  logic          is_status;
  logic          is_dig;
  logic          commit;
  logic          push;
  logic          pop;
  logic          ov_set;
  logic          fin_last;
  logic          busy;
  logic [31:0]   rd_val;

  logic [512:0]  head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;

  seq_state_t    state;
  logic          core_start;
  logic          done_d;
  logic [511:0]  hold_msg;
  logic          hold_last;
  logic          in_flight;
  logic [511:0]  core_msg;
  logic          core_last;
  logic          core_done;
  logic [255:0]  core_digest;

  assign wr        = ~iChipSelect_n & ~iWrite_n;
  assign rd        = ~iChipSelect_n & ~iRead_n;
  assign is_msg    = (iAddress[ADDR_W-1:4] == '0);
  assign is_ctrl   = (iAddress == ADDR_W'(CTRL));
  assign is_status = (iAddress == ADDR_W'(STATUS));
  assign is_dig    = (iAddress[ADDR_W-1:3] == (ADDR_W-3)'(DIGEST_BASE >> 3));

  assign commit   = wr & is_ctrl & iData[CTRL_COMMIT];
  assign push     = commit & ~full;
  assign ov_set   = commit & full;
  assign pop      = (state == S_START);
  assign fin_last = (state == S_FIN) & hold_last;
  assign busy     = (state != S_IDLE) | ~empty;

  // Address k holds the k-th most significant word of the block.
  always_comb begin
    staging = '0;
    for (int k = 0; k < 16; k++) staging[511 - 32*k -: 32] = stg[k];
  end

  sha256_blk_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (513)
  ) u_fifo (
    .clk   (iClk),
    .rst   (iReset),
    .push  (push),
    .pop   (pop),
    .din   ({iData[CTRL_LAST], staging}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // The head is presented until it is popped; from then on the holding
  // register keeps the core inputs stable for the rest of the job.
  assign in_flight = (state == S_WAIT) | (state == S_FIN);
  assign core_msg  = in_flight ? hold_msg  : head[511:0];
  assign core_last = in_flight ? hold_last : head[512];

  sha u_sha (
    .clk        (iClk),
    .reset_n    (~iReset),
    .start      (core_start),
    .message    (core_msg),
    .last_block (core_last),
    .done       (core_done),
    .digest     (core_digest)
  );

  // Sequencer: done_d lets WAIT react only to a fresh rising edge of the
  // core's done level, ignoring the stale level left by the previous block.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= S_IDLE;
      core_start <= 1'b0;
      done_d     <= 1'b0;
      hold_last  <= 1'b0;
    end else begin
      done_d     <= core_done;
      core_start <= 1'b0;
      case (state)
        S_IDLE:  if (!empty) state <= S_LOAD;
        S_LOAD: begin
          core_start <= 1'b1;
          state      <= S_START;
        end
        S_START: begin
          hold_msg  <= head[511:0];
          hold_last <= head[512];
          state     <= S_WAIT;
        end
        S_WAIT:  if (core_done && !done_d) state <= S_FIN;
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    if (is_ctrl) begin
      rd_val[CTRL_IRQ_EN] = irq_en;
    end else if (is_status) begin
      rd_val[ST_DONE]        = done_sticky;
      rd_val[ST_BUSY]        = busy;
      rd_val[ST_FULL]        = full;
      rd_val[ST_OVF]         = overflow;
      rd_val[ST_COUNT +: CW] = count;
    end else if (is_dig) begin
      rd_val = digest_q[255 - 32*int'(iAddress[2:0]) -: 32];
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int k = 0; k < 16; k++) stg[k] <= '0;
      digest_q    <= '0;
      irq_en      <= 1'b0;
      done_sticky <= 1'b0;
      overflow    <= 1'b0;
      oIrq        <= 1'b0;
      oData       <= '0;
    end else begin
      if (wr && is_msg) stg[iAddress[3:0]] <= iData;
      if (wr && is_ctrl) irq_en <= iData[CTRL_IRQ_EN];

      if (fin_last)
        done_sticky <= 1'b1;
      else if (wr && is_status && iData[ST_DONE])
        done_sticky <= 1'b0;

      if (ov_set)
        overflow <= 1'b1;
      else if (wr && is_status && iData[ST_OVF])
        overflow <= 1'b0;

      if (fin_last) digest_q <= core_digest;
      oIrq <= irq_en & done_sticky;
      if (rd) oData <= rd_val;
    end
  end

endmodule
